// File: rtl/serial_pattern_gen.sv
// Serial test-pattern transmitter: latches a parallel pattern on start and shifts it out
// MSB-first on W, one bit per BIT_CYCLES clocks, with a mid-bit strobe on bit_clk.
module serial_pattern_gen #(
   parameter int unsigned BIT_CYCLES = 10000,
   parameter int unsigned WIDTH      = 16
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [4:0]       length,
   input  logic [3:0]       repeats,
   output logic             W,
   output logic             bit_clk,
   output logic             busy,
   output logic             done
);

   localparam int unsigned PW = $clog2(BIT_CYCLES);
   localparam int unsigned IW = $clog2(WIDTH);
   localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(BIT_CYCLES / 2);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [IW-1:0]    last_q, last_d;
   logic [3:0]       rep_q, rep_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [4:0]       len_eff;
   logic [IW-1:0]    last_eff;
   logic             w_d, bit_clk_d, busy_d, done_d;

   // Zero or oversize length falls back to the full register width.
   always_comb begin
      len_eff = length;
      if (length == 5'd0 || {27'd0, length} > WIDTH) begin
         len_eff = 5'(WIDTH);
      end
      last_eff = IW'(len_eff - 5'd1);
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      last_d  = last_q;
      rep_d   = rep_q;
      pat_d   = pat_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSend;
               phase_d = '0;
               pat_d   = pattern;
               last_d  = last_eff;
               idx_d   = last_eff;
               rep_d   = repeats;
            end
         end
         StSend: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (idx_q != '0) begin
                  idx_d = idx_q - 1'b1;
               end else if (rep_q != 4'd0) begin
                  idx_d = last_q;
                  rep_d = rep_q - 4'd1;
               end else begin
                  state_d = StDone;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered from next-state values so they line up with the counters.
      w_d       = (state_d == StSend) ? pat_d[idx_d] : 1'b0;
      bit_clk_d = (state_d == StSend) && (phase_d >= PH_HALF);
      busy_d    = (state_d == StSend);
      done_d    = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         phase_q <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         rep_q   <= '0;
         pat_q   <= '0;
         W       <= 1'b0;
         bit_clk <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         rep_q   <= rep_d;
         pat_q   <= pat_d;
         W       <= w_d;
         bit_clk <= bit_clk_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen: stimulus queues expected transfers, monitors
// rebuild each transfer from W/bit_clk/busy and compare when done pulses.
module tb_serial_pattern_gen;

   logic        clk = 1'b0;
   logic        Reset;
   logic        start, start5;
   logic [15:0] pattern, pattern5;
   logic [4:0]  length, length5;
   logic [3:0]  repeats, repeats5;
   logic        W, bit_clk, busy, done;
   logic        W5, bit_clk5, busy5, done5;

   always #5 clk = ~clk;

   serial_pattern_gen #(.BIT_CYCLES(4), .WIDTH(16)) dut (
      .clk(clk), .Reset(Reset), .start(start), .pattern(pattern), .length(length),
      .repeats(repeats), .W(W), .bit_clk(bit_clk), .busy(busy), .done(done)
   );

   serial_pattern_gen #(.BIT_CYCLES(5), .WIDTH(16)) dut5 (
      .clk(clk), .Reset(Reset), .start(start5), .pattern(pattern5), .length(length5),
      .repeats(repeats5), .W(W5), .bit_clk(bit_clk5), .busy(busy5), .done(done5)
   );

   typedef struct {
      logic [63:0] bits;
      int          nbits;
      int          cycles;
   } exp_t;

   typedef struct {
      int cycles;
      int high;
      int ones;
      int rises;
   } exp5_t;

   exp_t  exp_q[$];
   exp5_t exp5_q[$];
   int    rise_q[$];
   int    checks = 0;
   int    failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor for the BIT_CYCLES=4 instance.
   logic w_hist[0:255];
   logic b_hist[0:255];
   int   n = 0, rises = 0, cyc = 0, done_cnt = 0;
   int   werr, berr, bi;
   logic prev_b = 1'b0, prev_busy = 1'b0, ew, eb;
   exp_t e;

   always @(negedge clk) begin
      cyc++;
      if (!Reset) begin
         n = 0; rises = 0; prev_b = 1'b0; prev_busy = 1'b0;
      end else begin
         if (busy && !prev_busy) rise_q.push_back(cyc);
         prev_busy = busy;
         if (busy) begin
            if (n < 256) begin
               w_hist[n] = W;
               b_hist[n] = bit_clk;
            end
            n++;
            if (bit_clk && !prev_b) rises++;
         end else begin
            check("idle_w_bitclk", int'({W, bit_clk}), 0);
         end
         prev_b = bit_clk;
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", done_cnt, 0);
            end else begin
               e = exp_q.pop_front();
               check("busy_cycles", n, e.cycles);
               check("bitclk_rises", rises, e.nbits);
               werr = 0; berr = 0;
               for (int i = 0; i < n && i < 256; i++) begin
                  bi = e.nbits - 1 - i / 4;
                  ew = (bi >= 0) ? e.bits[bi] : 1'b0;
                  eb = ((i % 4) >= 2);
                  if (w_hist[i] != ew) werr++;
                  if (b_hist[i] != eb) berr++;
               end
               check("w_stream_errors", werr, 0);
               check("bitclk_stream_errors", berr, 0);
            end
            n = 0; rises = 0;
         end
      end
   end

   // Monitor for the BIT_CYCLES=5 instance.
   int    n5 = 0, hi5 = 0, ones5 = 0, rises5 = 0, done5_cnt = 0;
   logic  prev_b5 = 1'b0;
   exp5_t e5;

   always @(negedge clk) begin
      if (!Reset) begin
         n5 = 0; hi5 = 0; ones5 = 0; rises5 = 0; prev_b5 = 1'b0;
      end else begin
         if (busy5) begin
            n5++;
            if (bit_clk5) hi5++;
            if (W5) ones5++;
            if (bit_clk5 && !prev_b5) rises5++;
         end
         prev_b5 = bit_clk5;
         if (done5) begin
            done5_cnt++;
            if (exp5_q.size() == 0) begin
               check("unexpected_done5", done5_cnt, 0);
            end else begin
               e5 = exp5_q.pop_front();
               check("bc5_busy_cycles", n5, e5.cycles);
               check("bc5_bitclk_high", hi5, e5.high);
               check("bc5_w_ones", ones5, e5.ones);
               check("bc5_rises", rises5, e5.rises);
            end
            n5 = 0; hi5 = 0; ones5 = 0; rises5 = 0;
         end
      end
   end

   task automatic push(input logic [63:0] bits, input int nbits, input int cycles);
      exp_t x;
      x.bits = bits; x.nbits = nbits; x.cycles = cycles;
      exp_q.push_back(x);
   endtask

   task automatic go(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
      @(negedge clk);
      pattern = p; length = l; repeats = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_dones(input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt < target) check("timeout_done", done_cnt, target);
   endtask

   task automatic wait_done_level(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done) check("timeout_done_level", int'(done), 1);
   endtask

   int r0, r1, r2, seen;
   exp5_t x5;

   initial begin
      Reset = 1'b0; start = 1'b1;
      pattern = 16'($urandom); length = 5'($urandom); repeats = 4'($urandom);
      start5 = 1'b1; pattern5 = 16'h000F; length5 = 5'd4; repeats5 = 4'd2;
      repeat (3) @(negedge clk);
      check("reset_outputs", int'({W, bit_clk, busy, done}), 0);
      check("reset_outputs5", int'({W5, bit_clk5, busy5, done5}), 0);
      start = 1'b0; start5 = 1'b0;
      #2 Reset = 1'b1;

      // Basic send.
      push(64'b1001, 4, 16);
      go(16'h0009, 5'd4, 4'd0);
      wait_dones(1, 40);

      // Length 0 and oversize both mean 16 bits.
      push(64'hF00F, 16, 64);
      go(16'hF00F, 5'd0, 4'd0);
      wait_dones(2, 100);
      push(64'hF00F, 16, 64);
      go(16'hF00F, 5'd20, 4'd0);
      wait_dones(3, 100);

      // Repeats, plus the BIT_CYCLES=5 duty check.
      x5.cycles = 60; x5.high = 36; x5.ones = 60; x5.rises = 12;
      exp5_q.push_back(x5);
      @(negedge clk) start5 = 1'b1;
      @(negedge clk) start5 = 1'b0;
      push(64'hFFF, 12, 48);
      go(16'h000F, 5'd4, 4'd2);
      wait_dones(4, 80);
      for (int k = 0; k < 40 && done5_cnt < 1; k++) @(negedge clk);
      check("done5_count", done5_cnt, 1);

      // Inputs and start changed mid-transfer are ignored.
      push(64'b1001, 4, 16);
      go(16'h0009, 5'd4, 4'd0);
      repeat (5) @(negedge clk);
      pattern = 16'hFFFF; length = 5'd7; start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_dones(5, 40);

      // start high during the DONE cycle is ignored.
      push(64'b1001, 4, 16);
      go(16'h0009, 5'd4, 4'd0);
      wait_done_level(40);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (30) @(negedge clk);
      check("done_count_after_done_start", done_cnt, 6);

      // start held high restarts every 18 cycles.
      push(64'b1001, 4, 16);
      push(64'b1001, 4, 16);
      push(64'b1001, 4, 16);
      @(negedge clk);
      pattern = 16'h0009; length = 5'd4; repeats = 4'd0; start = 1'b1;
      seen = 0;
      for (int k = 0; k < 120 && seen < 3; k++) begin
         @(negedge clk);
         if (done) seen++;
      end
      start = 1'b0;
      check("held_start_transfers", seen, 3);
      if (rise_q.size() >= 3) begin
         r0 = rise_q[rise_q.size() - 3];
         r1 = rise_q[rise_q.size() - 2];
         r2 = rise_q[rise_q.size() - 1];
         check("held_spacing_1", r1 - r0, 18);
         check("held_spacing_2", r2 - r1, 18);
      end else begin
         check("held_rise_count", rise_q.size(), 3);
      end
      repeat (4) @(negedge clk);

      // Mid-transfer asynchronous reset during bit 2, phase 1.
      go(16'h000D, 5'd4, 4'd0);
      repeat (5) @(negedge clk);
      check("pre_reset_busy", int'(busy), 1);
      #2 Reset = 1'b0;
      #1 check("async_clear", int'({W, bit_clk, busy, done}), 0);
      @(negedge clk);
      @(negedge clk);
      #2 Reset = 1'b1;
      push(64'b1101, 4, 16);
      go(16'h000D, 5'd4, 4'd0);
      wait_dones(10, 40);
      check("total_dones", done_cnt, 10);

      repeat (4) @(negedge clk);
      check("pending_expected", exp_q.size(), 0);
      check("pending_expected5", exp5_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial test-pattern transmitter: drives the single-bit serial stream (W) and its bit strobe (bit_clk) consumed by the lab's Moore sequence-detector FSMs, replacing hand-toggled switches and push buttons. A parallel pattern is latched on a start request and shifted out MSB-first at a fixed bit period derived from the board clock, optionally repeated back-to-back. A busy/done handshake lets a controller or testbench chain patterns.

## Interface
- BIT_CYCLES, 10000: clk cycles per transmitted bit; legal range 2..65535.
- WIDTH, 16: pattern register width in bits; legal range 2..16.
- clk  input  1  system clock, board MHz oscillator
- Reset  input  1  reset, asynchronous, active-low
- start  input  1  request to transmit; sampled only in IDLE
- pattern  input  WIDTH  bits to send; bit [len-1] is sent first
- length  input  5  number of bits to send; 0 or values above WIDTH mean WIDTH
- repeat  input  4  extra back-to-back repetitions (0 means send once, 15 means 16 times)
- W  output  1  serial data bit
- bit_clk  output  1  bit strobe; rising edge at mid-bit, when W is stable
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, SEND, DONE.
  - IDLE: W=0, bit_clk=0, busy=0, done=0.
  - IDLE -> SEND on any clk edge with start=1.
  - SEND -> DONE after the last phase cycle of the last bit of the last repetition.
  - DONE -> IDLE unconditionally after one cycle.
- On acceptance, latch pattern, effective length L, and repeat R into internal registers. Input changes after that have no effect until the next IDLE acceptance.
- Internal counters:
  - phase: 0..BIT_CYCLES-1, width ceil(log2(BIT_CYCLES)).
  - bit index: L-1 down to 0.
  - repetition: R down to 0.
- Each bit lasts exactly BIT_CYCLES clk cycles. W holds latched_pattern[bit index] for the whole bit.
- bit_clk=0 while phase < BIT_CYCLES/2 (integer floor), and 1 otherwise.
- At phase = BIT_CYCLES-1:
  - If bit index > 0, decrement it.
  - If bit index = 0 and repetition > 0, reload bit index to L-1 and decrement repetition. There is no gap between repetitions.
  - If bit index = 0 and repetition = 0, go to DONE.
- start is ignored in SEND and DONE; it is never queued.
- Reset=0 at any time forces IDLE and clears all outputs and counters, independent of clk. A transfer aborted by reset produces no done pulse.

## Timing
- Reset values: W=0, bit_clk=0, busy=0, done=0.
- All outputs are registered; no combinational input-to-output path.
- If start=1 at edge k (IDLE), then after edge k:
  - busy=1.
  - W = first bit.
  - bit_clk=0.
  - phase=0.
- First bit_clk rising edge comes after edge k+BIT_CYCLES/2.
- Total busy duration is exactly (R+1)*L*BIT_CYCLES cycles.
- Edge k+(R+1)*L*BIT_CYCLES, where the FSM enters DONE:
  - busy=0, done=1.
  - W=0, bit_clk=0.
- Next edge: done=0. The earliest next start is accepted at the edge after that, so there are 2 idle cycles between transfers minimum.
- start held high continuously restarts the transfer every (R+1)*L*BIT_CYCLES+2 cycles.
- A downstream FSM clocked on posedge bit_clk samples each bit exactly once, at mid-bit.

## Test plan
All scenarios use BIT_CYCLES=4 and WIDTH=16 unless stated.
- Reset: hold Reset=0 with start=1 and random inputs -> W, bit_clk, busy, done all 0. Pulse Reset low asynchronously between clk edges -> outputs clear before the next edge.
- Basic send: pattern=16'h0009, length=4, repeat=0, one-cycle start -> W sequence 1,0,0,1, each held 4 cycles. bit_clk per bit is 0,0,1,1. busy high 16 cycles. done pulses at cycle 16 after start. Exactly 4 bit_clk rising edges.
- Length wrap: pattern=16'hF00F with length=0, then length=20 -> both send 16 bits 1111000000001111. busy high 64 cycles each.
- Repeat: pattern=16'h000F, length=4, repeat=2 -> 12 consecutive 1 bits with no gap. 48 busy cycles and exactly one done pulse. With BIT_CYCLES=5, bit_clk is high 3 of every 5 cycles.
- Ignored start/inputs: during SEND, change pattern to 16'hFFFF, change length, and pulse start -> output stream unchanged and no extra transfer. start=1 on the DONE cycle is also ignored. start held high throughout -> consecutive transfers spaced 18 cycles apart for L=4, R=0.
- Mid-transfer reset: assert Reset=0 during bit 2 phase 1 -> immediate IDLE outputs and no done. After release, a new start sends the full pattern from its first bit.
